ifetch_queue: RTL and testbench

//  Instruction-fetch front end directly upstream of the 5-stage datapath's IF/ID register.

---
 rtl/ifq_pkg.sv | 18 +
 rtl/ifetch_queue_chk.sv | 38 +++
 rtl/sync_fifo.sv | 77 +++++++
 rtl/ifetch_queue.sv | 123 ++++++++++++
 tb/tb_ifetch_queue.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ifq_pkg.sv
// Shared constants, the queue entry layout and PC arithmetic for the instruction-fetch queue.
package ifq_pkg;

    localparam int unsigned IFQ_DEPTH = 4;
    localparam int unsigned PTR_W     = $clog2(IFQ_DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/ifetch_queue_chk.sv
// Protocol checker for the fetch memory port; keeps its own count of requests in flight.
module ifetch_queue_chk #(
    parameter int unsigned DEPTH = 4
) (
    input logic       clk,
    input logic       rst,
    input logic       imem_req_valid,
    input logic       imem_req_ready,
    input logic [1:0] imem_req_addr_lo,
    input logic       imem_resp_valid
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] inflight_q;
    logic          fire_s, resp_s;

    assign fire_s = imem_req_valid && imem_req_ready;
    assign resp_s = imem_resp_valid && (inflight_q != '0);

    // Requests accepted by memory and not yet answered
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(fire_s) - CW'(resp_s);
        end
    end

    resp_needs_request: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (inflight_q != '0));

    req_word_aligned: assert property (@(posedge clk) disable iff (rst)
        imem_req_valid |-> (imem_req_addr_lo == 2'b00));

    inflight_bounded: assert property (@(posedge clk) disable iff (rst)
        inflight_q <= CW'(DEPTH));

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a same-cycle clear; head is read combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [WIDTH-1:0]       head_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign do_pop_s  = pop_i && (count_q != '0);
    assign do_push_s = push_i && ((count_q != (PW+1)'(DEPTH)) || do_pop_s);

    // Pointer and occupancy next state; clear empties without touching storage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (PW+1)'(do_push_s) - (PW+1)'(do_pop_s);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push_s && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order response queue,
// and wrong-path discard after a redirect.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcplus4F
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] q_count_s, pcf_count_s;
    logic [CW:0]   credit_s;
    logic          req_fire_s, resp_s, keep_resp_s, pop_s;
    logic          q_empty_s, q_full_s, pcf_empty_s, pcf_full_s;
    logic [31:0]   pcf_head_s;
    ifq_entry_t    q_head_s, q_push_s;
    logic          unused_s;

    // Queued entries plus requests still in flight may never exceed the queue size
    assign credit_s       = {1'b0, q_count_s} + {1'b0, outstanding_q};
    assign imem_req_valid = !rst && !redirect && (credit_s < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire_s     = imem_req_valid && imem_req_ready;

    assign resp_s      = imem_resp_valid && (outstanding_q != '0);
    assign keep_resp_s = resp_s && (drop_q == '0) && !redirect;
    assign q_push_s    = '{pc: pcf_head_s, instr: imem_resp_data};

    assign instr_valid = !rst && !q_empty_s;
    assign pop_s       = instr_valid && !stall && !redirect;
    assign instrF      = instr_valid ? q_head_s.instr : NOP_INSTR;
    assign pcF         = instr_valid ? q_head_s.pc : 32'h0000_0000;
    assign pcplus4F    = instr_valid ? pc_inc(q_head_s.pc) : 32'h0000_0000;

    // Fetch PC, in-flight and wrong-path drop counters
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(resp_s);
        drop_d        = drop_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            drop_d     = outstanding_q - CW'(resp_s);
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = pc_inc(fetch_pc_q);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (resp_s && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1'b1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH($bits(ifq_entry_t)),
        .DEPTH(DEPTH)
    ) u_instr_q (
        .clk        (clk),
        .rst        (rst),
        .push_i     (keep_resp_s),
        .push_data_i(q_push_s),
        .pop_i      (pop_s),
        .clear_i    (redirect),
        .full_o     (q_full_s),
        .empty_o    (q_empty_s),
        .count_o    (q_count_s),
        .head_o     (q_head_s)
    );

    // PCs of requests in flight; entries of wrong-path requests vanish with the clear
    sync_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_pc_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (req_fire_s),
        .push_data_i(fetch_pc_q),
        .pop_i      (keep_resp_s),
        .clear_i    (redirect),
        .full_o     (pcf_full_s),
        .empty_o    (pcf_empty_s),
        .count_o    (pcf_count_s),
        .head_o     (pcf_head_s)
    );

    assign unused_s = ^{q_full_s, pcf_full_s, pcf_empty_s, pcf_count_s, redirect_pc[1:0]};

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed vector table plus wrap-around and randomized-ready/reset scoreboard sequences.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instrF, pcF, pcplus4F;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instrF(instrF),
        .pcF(pcF), .pcplus4F(pcplus4F)
    );

    ifetch_queue_chk #(.DEPTH(4)) u_chk (
        .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_req_addr_lo(imem_req_addr[1:0]),
        .imem_resp_valid(imem_resp_valid)
    );

    typedef struct { logic [31:0] pc; int due; } mreq_t;
    typedef struct {
        bit rst_v; bit stall_v; bit redir_v; logic [31:0] rpc; int lat;
        bit rv; logic [31:0] addr; bit iv; logic [31:0] pc;
    } vec_t;

    mreq_t mq[$];
    vec_t  vq[$];
    int    cyc = 0;
    int    cur_lat = 1;
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit s, input bit d, input logic [31:0] rpc, input int lat,
                       input bit rv, input logic [31:0] addr, input bit iv, input logic [31:0] pc);
        vec_t v;
        v.rst_v = r; v.stall_v = s; v.redir_v = d; v.rpc = rpc; v.lat = lat;
        v.rv = rv; v.addr = addr; v.iv = iv; v.pc = pc;
        vq.push_back(v);
    endtask

    // One clock: sample the request port, update the in-order memory model, drive the next response.
    task automatic step();
        logic        fire, rsp;
        logic [31:0] addr;
        mreq_t       m;
        fire = imem_req_valid && imem_req_ready;
        addr = imem_req_addr;
        rsp  = imem_resp_valid;
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (rsp && mq.size() > 0) void'(mq.pop_front());
            if (fire) begin
                m.pc = addr; m.due = cyc + cur_lat;
                mq.push_back(m);
            end
        end
        @(negedge clk);
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(mq[0].pc);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    endtask

    task automatic chk_head(input string tag, input bit iv, input logic [31:0] pc);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(iv));
        chk({tag, " pcF"}, pcF, iv ? pc : 32'h0);
        chk({tag, " instrF"}, instrF, iv ? instr_of(pc) : 32'h0);
        chk({tag, " pcplus4F"}, pcplus4F, iv ? pc + 32'd4 : 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int consumed;
        logic [31:0] exp_pc;

        // Steady fetch, latency 1
        add(1'b1,1'b0,1'b0,32'h0,1, 1'b0,32'h0,  1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b1,32'h0,  1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b1,32'h4,  1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b1,32'h8,  1'b1,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b1,32'hC,  1'b1,32'h4);
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b1,32'h10, 1'b1,32'h8);
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b1,32'h14, 1'b1,32'hC);
        // Stall for 10 cycles: queue fills to 4, requests stop, head holds
        add(1'b0,1'b1,1'b0,32'h0,1, 1'b1,32'h18, 1'b1,32'h10);
        add(1'b0,1'b1,1'b0,32'h0,1, 1'b1,32'h1C, 1'b1,32'h10);
        for (int k = 0; k < 8; k++) add(1'b0,1'b1,1'b0,32'h0,1, 1'b0,32'h0, 1'b1,32'h10);
        // Release: drain in order
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b0,32'h0,  1'b1,32'h10);
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b1,32'h20, 1'b1,32'h14);
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b1,32'h24, 1'b1,32'h18);
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b1,32'h28, 1'b1,32'h1C);
        add(1'b0,1'b0,1'b0,32'h0,1, 1'b1,32'h2C, 1'b1,32'h20);
        // Reset mid-stream, then latency 3 with redirect while 3 requests are in flight
        add(1'b1,1'b0,1'b0,32'h0,1, 1'b0,32'h0,  1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h0,  1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h4,  1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h8,  1'b0,32'h0);
        add(1'b0,1'b0,1'b1,32'h100,3, 1'b0,32'h0, 1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h100, 1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h104, 1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h108, 1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h10C, 1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b0,32'h0,   1'b1,32'h100);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h110, 1'b1,32'h104);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h114, 1'b1,32'h108);
        // Redirect together with a response and stall, with a valid head present
        add(1'b0,1'b1,1'b0,32'h0,3, 1'b1,32'h118, 1'b1,32'h10C);
        add(1'b0,1'b1,1'b1,32'h203,3, 1'b0,32'h0, 1'b1,32'h10C);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h200, 1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h204, 1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h208, 1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h20C, 1'b0,32'h0);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b0,32'h0,   1'b1,32'h200);
        add(1'b0,1'b0,1'b0,32'h0,3, 1'b1,32'h210, 1'b1,32'h204);

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst_v; stall = vq[i].stall_v; redirect = vq[i].redir_v;
            redirect_pc = vq[i].rpc; cur_lat = vq[i].lat; imem_req_ready = 1'b1;
            #1;
            chk($sformatf("v%0d req_valid", i), 32'(imem_req_valid), 32'(vq[i].rv));
            if (vq[i].rv) chk($sformatf("v%0d req_addr", i), imem_req_addr, vq[i].addr);
            chk_head($sformatf("v%0d", i), vq[i].iv, vq[i].pc);
            step();
        end

        // Address wrap at the top of memory
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; cur_lat = 1; #1;
        step();
        rst = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
        chk("wrap redirect req_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect = 1'b0; #1;
        chk("wrap addr0", imem_req_addr, 32'hFFFF_FFF8);
        step(); #1;
        chk("wrap addr1", imem_req_addr, 32'hFFFF_FFFC);
        step(); #1;
        chk("wrap addr2", imem_req_addr, 32'h0000_0000);
        chk_head("wrap h0", 1'b1, 32'hFFFF_FFF8);
        step(); #1;
        chk_head("wrap h1", 1'b1, 32'hFFFF_FFFC);
        chk("wrap addr3", imem_req_addr, 32'h0000_0004);
        step(); #1;
        chk_head("wrap h2", 1'b1, 32'h0000_0000);

        // Random ready/latency/stall with a reset pulse; in-order scoreboard on consumed words
        rst = 1'b1; #1;
        step();
        rst = 1'b0;
        exp_pc = 32'h0;
        consumed = 0;
        for (int c = 0; c < 300; c++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            stall   = ($urandom_range(0, 3) == 0);
            cur_lat = $urandom_range(1, 3);
            rst     = (c == 150 || c == 151);
            #1;
            if (rst) begin
                chk($sformatf("r%0d rst req_valid", c), 32'(imem_req_valid), 32'd0);
                chk_head($sformatf("r%0d rst", c), 1'b0, 32'h0);
                exp_pc = 32'h0;
            end else if (instr_valid && !stall) begin
                chk($sformatf("r%0d order pcF", c), pcF, exp_pc);
                chk($sformatf("r%0d order instrF", c), instrF, instr_of(exp_pc));
                chk($sformatf("r%0d order pcplus4F", c), pcplus4F, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            step();
        end
        chk("random progress (consumed>=40)", 32'(consumed >= 40), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
